alu_seq_divider: RTL

ALU_SEQ_DIVIDER -- requirements
Module: alu_seq_divider

---
 rtl/alu_seq_divider.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_seq_divider.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, MSB first.
// The trial subtraction runs through a parallel-prefix carry-lookahead adder.

module carry_lookahead #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             add_op_i,
  output logic [WIDTH-1:0] sum_o
);
  // add_op_i=1: a + b + cin.  add_op_i=0: a - b - cin (cin acts as borrow-in).
  always_comb begin : cla_prefix
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;
    logic             c0;
    b_eff = add_op_i ? b_i : ~b_i;
    c0    = add_op_i ? cin_i : ~cin_i;
    prop  = a_i ^ b_eff;
    grp_g = a_i & b_eff;
    grp_g[0] = grp_g[0] | (prop[0] & c0);
    grp_p = prop;
    // Kogge-Stone levels; descending i so grp_*[i-d] still holds the previous level.
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = WIDTH - 1; i >= d; i--) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
    sum_o = prop ^ {grp_g[WIDTH-2:0], c0};
  end
endmodule

module alu_seq_divider #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  div_by_zero_o
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  // work_q starts as the dividend and fills with quotient bits from the LSB end.
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;

  assign shifted = {rem_q, work_q[DATA_WIDTH-1]};

  carry_lookahead #(.WIDTH(DATA_WIDTH + 1)) u_trial_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, divisor_q}),
    .cin_i    (1'b0),
    .add_op_i (1'b0),
    .sum_o    (diff)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    work_d      = work_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          work_d    = dividend_i;
          divisor_d = divisor_i;
          rem_d     = '0;
          count_d   = '0;
          if (divisor_i == '0) begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Negative difference means the divisor did not fit: restore.
        rem_d   = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        work_d  = {work_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          count_d     = '0;
          quotient_d  = work_d;
          remainder_d = rem_d;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    work_q    <= work_d;
    divisor_q <= divisor_d;
    rem_q     <= rem_d;
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;
endmodule
